// File: rtl/gen_clk.sv
// -----------------------------------------------------------------------------
// gen_clk : derives the neuron, simulation and spindle clocks from rawclk.
//   clk_out1 (neuron_clk)  : half-period of (half_cnt+1) rawclk cycles
//   clk_out2 (sim_clk)     : neuron counter bit NN-1
//   clk_out3 (spindle_clk) : neuron counter bit NN-2 (twice the sim_clk rate)
// Every output comes straight from a flip-flop clocked by rawclk, so all
// outputs are glitch-free and change on the same rawclk rising edges.
// -----------------------------------------------------------------------------
module gen_clk #(
   parameter int NN = 8                       // neurons per step = 2**NN, NN >= 2
) (
   input  logic              rawclk,
   input  logic              reset,           // asynchronous, active-low
   input  logic [17:0]       half_cnt,
   output logic              clk_out1,
   output logic              clk_out2,
   output logic              clk_out3,
   output logic [NN+2:0]     int_neuron_cnt_out
);

   localparam int CW = NN + 3;

   logic [17:0]   r_div_cnt;
   logic          r_neuron_clk;
   logic [CW-1:0] r_neuron_cnt;

   // Terminal count: ">=" rather than "==" so that lowering half_cnt while
   // the divider is already past the new value ends the half-period on the
   // very next edge instead of running the counter all the way round 2^18.
   logic          w_div_done;
   // The neuron clock is about to go 0->1 on this edge.
   logic          w_neuron_rise;

   assign w_div_done    = (r_div_cnt >= half_cnt);
   assign w_neuron_rise = w_div_done && !r_neuron_clk;

   // Divider: count rawclk edges within the current neuron-clock half-period.
   always_ff @(posedge rawclk or negedge reset) begin
      if (!reset) begin
         r_div_cnt <= '0;
      end else if (w_div_done) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 18'd1;
      end
   end

   // Neuron clock: toggle at the end of every half-period.
   always_ff @(posedge rawclk or negedge reset) begin
      if (!reset) begin
         r_neuron_clk <= 1'b0;
      end else if (w_div_done) begin
         r_neuron_clk <= ~r_neuron_clk;
      end
   end

   // Neuron counter: advances on the same edge the neuron clock rises and
   // wraps naturally at 2^(NN+3); its upper bits form the slower clocks.
   always_ff @(posedge rawclk or negedge reset) begin
      if (!reset) begin
         r_neuron_cnt <= '0;
      end else if (w_neuron_rise) begin
         r_neuron_cnt <= r_neuron_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Outputs are plain register taps with no logic in between.
   assign clk_out1           = r_neuron_clk;
   assign clk_out2           = r_neuron_cnt[NN-1];
   assign clk_out3           = r_neuron_cnt[NN-2];
   assign int_neuron_cnt_out = r_neuron_cnt;

endmodule

// File: tb/tb_gen_clk.sv
// -----------------------------------------------------------------------------
// tb_gen_clk : randomized and directed checks of gen_clk against a timing
// model that tracks elapsed rawclk edges and the total number of neuron-clock
// rises as plain integers.
// -----------------------------------------------------------------------------
module tb_gen_clk;

   localparam int NN   = 8;
   localparam int CW   = NN + 3;
   localparam int CMOD = 1 << CW;

   logic          rawclk = 1'b0;
   logic          reset  = 1'b0;
   logic [17:0]   half_cnt = '0;
   logic          clk_out1;
   logic          clk_out2;
   logic          clk_out3;
   logic [CW-1:0] int_neuron_cnt_out;

   gen_clk #(.NN(NN)) dut (
      .rawclk             (rawclk),
      .reset              (reset),
      .half_cnt           (half_cnt),
      .clk_out1           (clk_out1),
      .clk_out2           (clk_out2),
      .clk_out3           (clk_out3),
      .int_neuron_cnt_out (int_neuron_cnt_out)
   );

   // 10 ns rawclk
   always #5 rawclk = ~rawclk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: edges since the neuron clock last changed, its level,
   // and the total number of rising edges since reset.
   int m_elapsed = 0;
   bit m_level   = 1'b0;
   int m_rises   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_elapsed = 0;
      m_level   = 1'b0;
      m_rises   = 0;
   endtask

   // One rawclk cycle: advance the model on the rising edge, compare all
   // outputs on the following falling edge.
   task automatic tick();
      @(posedge rawclk);
      if (reset) begin
         m_elapsed++;
         // a half-period lasts half_cnt+1 edges; a shorter new value ends it now
         if (m_elapsed >= int'(half_cnt) + 1) begin
            m_level   = !m_level;
            m_elapsed = 0;
            if (m_level) m_rises++;
         end
      end else begin
         model_clear();
      end
      @(negedge rawclk);
      check("clk1", {31'd0, clk_out1}, {31'd0, m_level});
      check("cnt",  {{(32-CW){1'b0}}, int_neuron_cnt_out}, 32'(m_rises % CMOD));
      check("clk2", {31'd0, clk_out2}, 32'((m_rises >> (NN-1)) & 1));
      check("clk3", {31'd0, clk_out3}, 32'((m_rises >> (NN-2)) & 1));
   endtask

   // Asynchronous reset pulse placed between rawclk edges.
   task automatic pulse_reset();
      #1 reset = 1'b0;
      #1;
      check("rst_async", {28'd0, clk_out1, clk_out2, clk_out3, 1'b0} | {{(32-CW){1'b0}}, int_neuron_cnt_out}, 32'd0);
      model_clear();
      tick();
      #1 reset = 1'b1;
      $display("reset pulse done at %0t", $time);
   endtask

   initial begin
      int edges;
      bit prev;

      // ---- power-up reset ----
      half_cnt = 18'd197;
      #2;
      check("rst_init", {28'd0, clk_out1, clk_out2, clk_out3, 1'b0} | {{(32-CW){1'b0}}, int_neuron_cnt_out}, 32'd0);
      tick();
      tick();
      #1 reset = 1'b1;

      // ---- nominal timing: first rise on edge 198, then 396-edge period ----
      edges = 0;
      do begin tick(); edges++; end while (!clk_out1 && edges < 1000);
      check("nom_first_rise", 32'(edges), 32'd198);
      edges = 0;
      do begin tick(); edges++; end while (clk_out1 && edges < 1000);
      check("nom_high_len", 32'(edges), 32'd198);
      edges = 0;
      do begin tick(); edges++; end while (!clk_out1 && edges < 1000);
      check("nom_low_len", 32'(edges), 32'd198);
      $display("nominal period phase done at %0t", $time);

      // ---- mid-period reduction: at div count 150 switch 197 -> 10 ----
      pulse_reset();
      edges = 0;
      while (m_elapsed != 150 && edges < 1000) begin tick(); edges++; end
      check("mid_reach150", 32'(m_elapsed), 32'd150);
      half_cnt = 18'd10;
      prev = clk_out1;
      tick();
      check("mid_toggle_now", {31'd0, clk_out1}, {31'd0, !prev});
      edges = 0;
      prev = clk_out1;
      do begin tick(); edges++; end while (clk_out1 == prev && edges < 1000);
      check("mid_next_11", 32'(edges), 32'd11);
      $display("mid-period change phase done at %0t", $time);

      // ---- minimum divide and counter wrap (half_cnt = 0) ----
      half_cnt = 18'd0;
      pulse_reset();
      for (int i = 1; i <= 4096; i++) begin
         tick();
         if (i == 1)    check("min_first_rise", {31'd0, clk_out1}, 32'd1);
         if (i == 4093) check("wrap_pre",  {{(32-CW){1'b0}}, int_neuron_cnt_out}, 32'd2047);
         if (i == 4095) check("wrap_post", {{(32-CW){1'b0}}, int_neuron_cnt_out}, 32'd0);
      end
      $display("counter wrap phase done at %0t", $time);

      // ---- reset while sim clock is high ----
      edges = 0;
      while (!clk_out2 && edges < 2000) begin tick(); edges++; end
      check("sim_clk_high", {31'd0, clk_out2}, 32'd1);
      half_cnt = 18'd5;
      pulse_reset();
      edges = 0;
      do begin tick(); edges++; end while (!clk_out1 && edges < 100);
      check("rst_first_rise", 32'(edges), 32'd6);
      $display("mid-run reset phase done at %0t", $time);

      // ---- randomized run: varying half_cnt and occasional resets ----
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 49) == 0) half_cnt = 18'($urandom_range(0, 20));
         if ($urandom_range(0, 199) == 0) pulse_reset();
         tick();
      end
      $display("random phase done at %0t", $time);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gen_clk.md
GEN_CLK -- requirements
Module: gen_clk

Interface
REQ-001 Parameter NN, default 8, SHALL set the neuron-index width (neurons per simulation step = 2^NN); legal range NN >= 2.
REQ-002 Port rawclk, input, 1 bit, SHALL be the single base clock; every register in the block is clocked on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the reset; it is asynchronous and active-low.
REQ-004 Port half_cnt, input, 18 bits, unsigned, SHALL set the neuron-clock half-period to (half_cnt+1) rawclk cycles.
REQ-005 Port clk_out1, output, 1 bit, SHALL be the neuron clock (neuron_clk).
REQ-006 Port clk_out2, output, 1 bit, SHALL be the simulation clock (sim_clk).
REQ-007 Port clk_out3, output, 1 bit, SHALL be the spindle clock (spindle_clk), running at twice the sim_clk rate.
REQ-008 Port int_neuron_cnt_out, output, NN+3 bits, SHALL be the free-running count of neuron_clk rising edges.

Function
REQ-009 An 18-bit divider counter div_cnt SHALL be compared against half_cnt on every rawclk rising edge.
REQ-010 If div_cnt >= half_cnt: div_cnt SHALL load 0 and clk_out1 SHALL toggle on that edge.
REQ-011 Otherwise div_cnt SHALL increment by 1 and clk_out1 SHALL hold.
REQ-012 The >= comparison SHALL make a reduction of half_cnt mid-period take effect at the next edge, so the counter never wraps through 2^18.
REQ-013 half_cnt SHALL NOT be latched: changes apply from the next rawclk edge.
REQ-014 half_cnt = 0 SHALL make clk_out1 toggle every rawclk edge, giving a period of 2 rawclk cycles.
REQ-015 The neuron counter SHALL increment by 1 on the same rawclk edge where clk_out1 toggles 0->1.
REQ-016 The neuron counter SHALL hold on every other edge.
REQ-017 The neuron counter SHALL wrap from 2^(NN+3)-1 to 0 with no other side effect.
REQ-018 clk_out2 SHALL equal neuron counter bit NN-1, giving a period of 2^NN neuron_clk periods.
REQ-019 clk_out3 SHALL equal neuron counter bit NN-2, giving a period of 2^(NN-1) neuron_clk periods.
REQ-020 All outputs SHALL be driven directly from flip-flops, with no combinational logic after the register, so they are glitch-free.
REQ-021 All outputs SHALL be mutually aligned to rawclk rising edges.
REQ-022 int_neuron_cnt_out SHALL present the full neuron counter register.

Reset
REQ-023 While reset = 0, the following SHALL all be 0 immediately, independent of rawclk: div_cnt, clk_out1, the neuron counter (and so int_neuron_cnt_out), clk_out2, clk_out3.
REQ-024 After reset rises, the first clk_out1 rising edge SHALL occur on rawclk rising edge number half_cnt+1.
REQ-025 The neuron counter SHALL read 1 from that same edge.
REQ-026 Asserting reset mid-operation SHALL abort the current period; the sequence then restarts exactly as after power-up.

Verification
REQ-027 Nominal timing: NN=8, half_cnt=197, rawclk 10 ns period, reset released -> required periods:
- clk_out1: 3960 ns, 50% duty
- clk_out3: 506.88 us
- clk_out2: 1013.76 us
REQ-028 Minimum divide: half_cnt=0 -> clk_out1 toggles every rawclk edge; int_neuron_cnt_out increments every 2 rawclk cycles.
REQ-029 Counter wrap: NN=8, half_cnt=0, run 2048 clk_out1 rising edges -> int_neuron_cnt_out goes 2047 -> 0 with no glitch on clk_out1.
REQ-030 Counter wrap, derived clocks: same run as REQ-029 -> clk_out2 and clk_out3 stay continuous across the wrap.
REQ-031 Mid-period change: half_cnt=197, at div_cnt=150 set half_cnt=10 -> clk_out1 toggles on the next rawclk edge, then every 11 cycles.
REQ-032 Reset mid-run: pull reset low while clk_out2=1 -> all outputs 0 within the same timestep, without a rawclk edge; on release, first clk_out1 rise follows after half_cnt+1 edges.
